// File: rtl/sw_led_ctrl.sv
// Slide-switch to LED controller: per-channel two-flop sync, debounce, rising-edge
// pulses, toggle latches, and a shared blink generator feeding a mode-selected LED register.
module sw_led_ctrl #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_HALF      = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SW,
    input  logic [1:0]       MODE,
    input  logic             TOG_CLR,
    output logic [WIDTH-1:0] LED,
    output logic [WIDTH-1:0] SW_DB,
    output logic [WIDTH-1:0] SW_RISE
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    logic [WIDTH-1:0] sw_meta;
    logic [WIDTH-1:0] sw_s;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_nxt  [WIDTH];
    logic [WIDTH-1:0] db_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] tog_nxt;
    logic [BW-1:0]    blink_cnt;
    logic             phase;
    logic [WIDTH-1:0] led_nxt;

    // Two-stage synchroniser; sw_s is the only copy of SW the rest of the block sees.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= SW;
            sw_s    <= sw_meta;
        end
    end

    // A channel's counter only runs while the synchronised input disagrees with the accepted level.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        db_nxt   = SW_DB;
        rise_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (sw_s[i] == SW_DB[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                cnt_nxt[i]  = '0;
                db_nxt[i]   = sw_s[i];
                rise_nxt[i] = sw_s[i];
            end else begin
                cnt_nxt[i] = cnt[i] + CW'(1);
            end
        end
    end

    // NOTE: the counter array is reset because its value gates acceptance right after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            SW_DB   <= '0;
            SW_RISE <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            SW_DB   <= db_nxt;
            SW_RISE <= rise_nxt;
        end
    end

    // Clear dominates a coincident rise pulse.
    always_comb begin
        tog_nxt = tog ^ SW_RISE;
        if (TOG_CLR) begin
            tog_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tog <= '0;
        end else begin
            tog <= tog_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Mode only steers the output mux, so switching modes never disturbs latch or blink state.
    always_comb begin
        led_nxt = '0;
        case (mode_e'(MODE))
            MODE_DIRECT: led_nxt = SW_DB;
            MODE_TOGGLE: led_nxt = tog;
            MODE_BLINK:  led_nxt = SW_DB & {WIDTH{phase}};
            MODE_OFF:    led_nxt = '0;
            default:     led_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            LED <= '0;
        end else begin
            LED <= led_nxt;
        end
    end

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Self-checking bench for sw_led_ctrl: directed plan steps plus a randomised run,
// all compared every edge against a window/arithmetic reference model.
module tb_sw_led_ctrl;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int BH = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] SW = '0;
    logic [1:0]   MODE = 2'd0;
    logic         TOG_CLR = 1'b0;
    logic [W-1:0] LED;
    logic [W-1:0] SW_DB;
    logic [W-1:0] SW_RISE;

    sw_led_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .BLINK_HALF(BH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .SW(SW),
        .MODE(MODE),
        .TOG_CLR(TOG_CLR),
        .LED(LED),
        .SW_DB(SW_DB),
        .SW_RISE(SW_RISE)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: raw-sample history plus a few expected registers.
    logic [W-1:0] hist[$];
    int           n;
    int           last_change[W];
    int           rise_cnt[W];
    logic [W-1:0] m_db, m_rise, m_tog, m_led;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Synchronised value the DUT evaluates at edge k is the raw input captured at edge k-2.
    function automatic logic [W-1:0] seen(input int k);
        if (k >= 3) return hist[k-3];
        return '0;
    endfunction

    task automatic model_reset;
        hist.delete();
        n = 0;
        m_db = '0; m_rise = '0; m_tog = '0; m_led = '0;
        for (int i = 0; i < W; i++) begin
            last_change[i] = -100;
            rise_cnt[i] = 0;
        end
    endtask

    // A level is accepted once the last D synchronised samples all show it and the
    // channel has not changed within that window.
    task automatic model_edge;
        logic [W-1:0] pdb, prise, ptog, s;
        logic         pphase, v, ok;
        n++;
        hist.push_back(SW);
        pdb    = m_db;
        prise  = m_rise;
        ptog   = m_tog;
        pphase = (((n - 1) / BH) % 2) == 0;
        for (int i = 0; i < W; i++) begin
            m_rise[i] = 1'b0;
            v  = ~pdb[i];
            ok = (n - last_change[i]) >= D;
            for (int j = 0; j < D; j++) begin
                s = seen(n - j);
                if (s[i] !== v) ok = 1'b0;
            end
            if (ok) begin
                m_db[i]        = v;
                m_rise[i]      = v;
                last_change[i] = n;
            end
        end
        m_tog = TOG_CLR ? '0 : (ptog ^ prise);
        case (MODE)
            2'd0:    m_led = pdb;
            2'd1:    m_led = ptog;
            2'd2:    m_led = pdb & {W{pphase}};
            default: m_led = '0;
        endcase
    endtask

    // One clock: inputs were set at the preceding falling edge; outputs sampled 1 ns after the rising edge.
    task automatic cyc;
        @(posedge clk);
        #1;
        model_edge();
        check("model_sw_db", 32'(SW_DB), 32'(m_db));
        check("model_sw_rise", 32'(SW_RISE), 32'(m_rise));
        check("model_led", 32'(LED), 32'(m_led));
        for (int i = 0; i < W; i++) begin
            if (SW_RISE[i]) rise_cnt[i]++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #1;
        check("rst_led", 32'(LED), 32'd0);
        check("rst_sw_db", 32'(SW_DB), 32'd0);
        check("rst_sw_rise", 32'(SW_RISE), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_db(input logic [W-1:0] target, output int edges);
        edges = 0;
        while (SW_DB !== target && edges < 50) begin
            cyc();
            edges++;
        end
    endtask

    initial begin
        int edges;
        int toggles;
        logic prev;

        #2;
        do_reset();

        // Plan 1: basic acceptance latency and pulse.
        SW = 4'b0001;
        repeat (5) cyc();
        check("t1_db_before", 32'(SW_DB), 32'h0);
        cyc();
        check("t1_db_edge6", 32'(SW_DB), 32'h1);
        check("t1_rise_edge6", 32'(SW_RISE), 32'h1);
        check("t1_led_edge6", 32'(LED), 32'h0);
        cyc();
        check("t1_rise_gone", 32'(SW_RISE), 32'h0);
        check("t1_led_edge7", 32'(LED), 32'h1);

        // Plan 2: bounce restarts the count.
        do_reset();
        SW = 4'b0001; cyc(); cyc();
        SW = 4'b0000; cyc(); cyc();
        check("t2_db_bounce", 32'(SW_DB), 32'h0);
        SW = 4'b0001;
        wait_db(4'b0001, edges);
        check("t2_latency", 32'(edges), 32'd6);
        repeat (4) cyc();
        check("t2_one_rise", 32'(rise_cnt[0]), 32'd1);

        // Plan 3: toggle mode, then clear racing a rise.
        do_reset();
        MODE = 2'd1;
        SW = 4'b0010; repeat (10) cyc();
        check("t3_led_on", 32'(LED), 32'h2);
        SW = 4'b0000; repeat (10) cyc();
        check("t3_led_hold", 32'(LED), 32'h2);
        SW = 4'b0010; repeat (10) cyc();
        check("t3_led_off", 32'(LED), 32'h0);
        SW = 4'b0000; repeat (10) cyc();
        check("t3_led_end", 32'(LED), 32'h0);
        check("t3_db_end", 32'(SW_DB), 32'h0);
        SW = 4'b0010; repeat (6) cyc();
        check("t3_rise3", 32'(SW_RISE), 32'h2);
        TOG_CLR = 1'b1; cyc();
        TOG_CLR = 1'b0; repeat (3) cyc();
        check("t3_clr_wins", 32'(LED), 32'h0);

        // Plan 4: blink mode.
        do_reset();
        MODE = 2'd2;
        SW = 4'b1010;
        repeat (7) cyc();
        prev = LED[3];
        toggles = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            check("t4_even_off", 32'(LED & 4'b0101), 32'h0);
            check("t4_pair", 32'(LED[1]), 32'(LED[3]));
            if (LED[3] !== prev) toggles++;
            prev = LED[3];
        end
        check("t4_toggles", 32'(toggles), 32'd4);

        // Plan 5: off mode keeps debounce alive.
        do_reset();
        MODE = 2'd3;
        SW = 4'b1111;
        repeat (8) cyc();
        check("t5_led_off", 32'(LED), 32'h0);
        check("t5_db_off", 32'(SW_DB), 32'hF);
        MODE = 2'd0;
        cyc();
        check("t5_led_direct", 32'(LED), 32'hF);
        check("t5_db_direct", 32'(SW_DB), 32'hF);

        // Plan 6: reset mid-debounce.
        do_reset();
        SW = 4'b0001;
        repeat (8) cyc();
        check("t6_led_pre", 32'(LED), 32'h1);
        SW = 4'b0101;
        cyc(); cyc();
        do_reset();
        wait_db(4'b0101, edges);
        check("t6_latency", 32'(edges), 32'd6);

        // Randomised run against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 5) == 0) SW[i] = ~SW[i];
            end
            if ($urandom_range(0, 29) == 0) MODE = 2'($urandom_range(0, 3));
            TOG_CLR = ($urandom_range(0, 19) == 0);
            cyc();
        end
        TOG_CLR = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
